// File: rtl/ora_misr.sv
// Output-response analyser: a multiple-input signature register that compacts
// CUT responses and compares the final signature and response count against golden values.
module ora_misr #(
    parameter int unsigned        BITS      = 3,
    parameter logic [BITS-1:0]    POLY      = 3'b011,
    parameter logic [BITS-1:0]    SEED      = '0,
    parameter logic [BITS-1:0]    GOLDEN    = '0,
    parameter int unsigned        EXP_COUNT = 7,
    parameter int unsigned        CNT_BITS  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                EN,
    input  logic                END,
    input  logic [BITS-1:0]     RESPONSE,
    output logic [BITS-1:0]     SIGNATURE,
    output logic [CNT_BITS-1:0] COUNT,
    output logic                DONE,
    output logic                PASS
);

    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
    localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);
    localparam logic [CNT_BITS-1:0] EXP_CNT = CNT_BITS'(EXP_COUNT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPACT = 2'd1,
        CHECK   = 2'd2,
        HOLD    = 2'd3
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [BITS-1:0]       sig_d;
    logic [CNT_BITS-1:0]   cnt_d;
    logic                  done_d;
    logic                  pass_d;
    logic [BITS-1:0]       sig_step;
    logic [CNT_BITS-1:0]   cnt_inc;

    // One MISR shift with polynomial feedback and the response folded in.
    always_comb begin
        sig_step = {SIGNATURE[BITS-2:0], 1'b0}
                 ^ (SIGNATURE[BITS-1] ? POLY : BITS'(0))
                 ^ RESPONSE;
        cnt_inc  = (COUNT == CNT_MAX) ? COUNT : COUNT + CNT_ONE;
    end

    // Next-state and next-output logic; every path starts from "hold".
    always_comb begin
        state_d = state_q;
        sig_d   = SIGNATURE;
        cnt_d   = COUNT;
        done_d  = DONE;
        pass_d  = PASS;

        unique case (state_q)
            IDLE: begin
                if (EN) begin
                    sig_d   = sig_step;
                    cnt_d   = CNT_ONE;
                    state_d = END ? CHECK : COMPACT;
                end
            end
            COMPACT: begin
                if (EN) begin
                    sig_d   = sig_step;
                    cnt_d   = cnt_inc;
                    if (END) begin
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                pass_d  = (SIGNATURE == GOLDEN) && (COUNT == EXP_CNT);
                done_d  = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                state_d = HOLD;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset wins over any activity.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            SIGNATURE <= SEED;
            COUNT     <= '0;
            DONE      <= 1'b0;
            PASS      <= 1'b0;
        end else begin
            state_q   <= state_d;
            SIGNATURE <= sig_d;
            COUNT     <= cnt_d;
            DONE      <= done_d;
            PASS      <= pass_d;
        end
    end

endmodule

// File: tb/tb_ora_misr.sv
// Bench for ora_misr: table of hand-derived vectors plus model-driven sequences,
// checked through an expected-result queue against four differently parameterised instances.
module tb_ora_misr;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       fin;
    logic [2:0] resp;

    logic [2:0] sig_a, sig_b, sig_c, sig_s;
    logic [7:0] cnt_a, cnt_b, cnt_c;
    logic [1:0] cnt_s;
    logic       done_a, done_b, done_c, done_s;
    logic       pass_a, pass_b, pass_c, pass_s;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // a: golden 001 / 2 responses; b: golden 000; c: expects 3 responses; s: 2-bit counter
    ora_misr #(.BITS(3), .POLY(3'b011), .SEED(3'b000), .GOLDEN(3'b001), .EXP_COUNT(2), .CNT_BITS(8)) dut_a (
        .clk(clk), .rst(rst), .EN(en), .END(fin), .RESPONSE(resp),
        .SIGNATURE(sig_a), .COUNT(cnt_a), .DONE(done_a), .PASS(pass_a));
    ora_misr #(.BITS(3), .POLY(3'b011), .SEED(3'b000), .GOLDEN(3'b000), .EXP_COUNT(2), .CNT_BITS(8)) dut_b (
        .clk(clk), .rst(rst), .EN(en), .END(fin), .RESPONSE(resp),
        .SIGNATURE(sig_b), .COUNT(cnt_b), .DONE(done_b), .PASS(pass_b));
    ora_misr #(.BITS(3), .POLY(3'b011), .SEED(3'b000), .GOLDEN(3'b001), .EXP_COUNT(3), .CNT_BITS(8)) dut_c (
        .clk(clk), .rst(rst), .EN(en), .END(fin), .RESPONSE(resp),
        .SIGNATURE(sig_c), .COUNT(cnt_c), .DONE(done_c), .PASS(pass_c));
    ora_misr #(.BITS(3), .POLY(3'b011), .SEED(3'b000), .GOLDEN(3'b000), .EXP_COUNT(7), .CNT_BITS(2)) dut_s (
        .clk(clk), .rst(rst), .EN(en), .END(fin), .RESPONSE(resp),
        .SIGNATURE(sig_s), .COUNT(cnt_s), .DONE(done_s), .PASS(pass_s));

    typedef struct {
        logic       rst;
        logic       en;
        logic       fin;
        logic [2:0] resp;
        logic [2:0] sig;
        logic [7:0] cnt;
        logic       done;
        logic       pa;
        logic       pb;
        logic       pc;
    } vec_t;

    typedef struct {
        logic [2:0] sig;
        logic [7:0] cnt;
        logic [1:0] cnt_s;
        logic       done;
        logic       pa;
        logic       pb;
        logic       pc;
        logic       ps;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[24];

    // Signature update as GF(2) polynomial arithmetic: multiply by x, reduce by x^3+x+1.
    function automatic logic [2:0] model_step(input logic [2:0] s, input logic [2:0] r);
        logic [3:0] w;
        w = {s, 1'b0};
        if (w[3]) w = w ^ 4'b1011;
        return w[2:0] ^ r;
    endfunction

    task automatic chk(input string name, input int step, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
        end
    endtask

    // Drive one cycle, queue the expectation, sample after the edge and compare.
    task automatic cycle(input logic r, input logic e, input logic f, input logic [2:0] d,
                         input exp_t x, input int step);
        exp_t got;
        rst  = r;
        en   = e;
        fin  = f;
        resp = d;
        sb.push_back(x);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard step %0d: got empty queue expected entry", step);
        end else begin
            got = sb.pop_front();
            chk("sig_a",  step, 8'(sig_a),  8'(got.sig));
            chk("sig_b",  step, 8'(sig_b),  8'(got.sig));
            chk("sig_s",  step, 8'(sig_s),  8'(got.sig));
            chk("cnt_a",  step, cnt_a,      got.cnt);
            chk("cnt_c",  step, cnt_c,      got.cnt);
            chk("cnt_s",  step, 8'(cnt_s),  8'(got.cnt_s));
            chk("done_a", step, 8'(done_a), 8'(got.done));
            chk("done_c", step, 8'(done_c), 8'(got.done));
            chk("pass_a", step, 8'(pass_a), 8'(got.pa));
            chk("pass_b", step, 8'(pass_b), 8'(got.pb));
            chk("pass_c", step, 8'(pass_c), 8'(got.pc));
            chk("pass_s", step, 8'(pass_s), 8'(got.ps));
        end
    endtask

    initial begin
        exp_t x;
        logic [2:0] m_sig;
        logic [7:0] m_cnt;
        logic [1:0] m_cnt_s;
        logic [2:0] r;
        logic       e;

        //        rst  en   end  resp    sig     cnt  done pa   pb   pc
        tbl[0]  = '{1'b1,1'b1,1'b0,3'b111, 3'b000, 8'd0,1'b0,1'b0,1'b0,1'b0};
        tbl[1]  = '{1'b0,1'b0,1'b0,3'b000, 3'b000, 8'd0,1'b0,1'b0,1'b0,1'b0};
        tbl[2]  = '{1'b0,1'b0,1'b1,3'b110, 3'b000, 8'd0,1'b0,1'b0,1'b0,1'b0};
        tbl[3]  = '{1'b0,1'b1,1'b0,3'b101, 3'b101, 8'd1,1'b0,1'b0,1'b0,1'b0};
        tbl[4]  = '{1'b0,1'b0,1'b1,3'b111, 3'b101, 8'd1,1'b0,1'b0,1'b0,1'b0};
        tbl[5]  = '{1'b0,1'b0,1'b0,3'b010, 3'b101, 8'd1,1'b0,1'b0,1'b0,1'b0};
        tbl[6]  = '{1'b0,1'b1,1'b1,3'b000, 3'b001, 8'd2,1'b0,1'b0,1'b0,1'b0};
        tbl[7]  = '{1'b0,1'b1,1'b0,3'b111, 3'b001, 8'd2,1'b1,1'b1,1'b0,1'b0};
        tbl[8]  = '{1'b0,1'b1,1'b0,3'b110, 3'b001, 8'd2,1'b1,1'b1,1'b0,1'b0};
        tbl[9]  = '{1'b0,1'b1,1'b1,3'b011, 3'b001, 8'd2,1'b1,1'b1,1'b0,1'b0};
        tbl[10] = '{1'b1,1'b1,1'b1,3'b111, 3'b000, 8'd0,1'b0,1'b0,1'b0,1'b0};
        tbl[11] = '{1'b0,1'b1,1'b0,3'b101, 3'b101, 8'd1,1'b0,1'b0,1'b0,1'b0};
        tbl[12] = '{1'b0,1'b1,1'b1,3'b000, 3'b001, 8'd2,1'b0,1'b0,1'b0,1'b0};
        tbl[13] = '{1'b0,1'b0,1'b0,3'b000, 3'b001, 8'd2,1'b1,1'b1,1'b0,1'b0};
        tbl[14] = '{1'b1,1'b0,1'b0,3'b000, 3'b000, 8'd0,1'b0,1'b0,1'b0,1'b0};
        tbl[15] = '{1'b0,1'b1,1'b0,3'b011, 3'b011, 8'd1,1'b0,1'b0,1'b0,1'b0};
        tbl[16] = '{1'b1,1'b1,1'b0,3'b111, 3'b000, 8'd0,1'b0,1'b0,1'b0,1'b0};
        tbl[17] = '{1'b0,1'b0,1'b0,3'b000, 3'b000, 8'd0,1'b0,1'b0,1'b0,1'b0};
        tbl[18] = '{1'b0,1'b1,1'b0,3'b101, 3'b101, 8'd1,1'b0,1'b0,1'b0,1'b0};
        tbl[19] = '{1'b0,1'b1,1'b1,3'b000, 3'b001, 8'd2,1'b0,1'b0,1'b0,1'b0};
        tbl[20] = '{1'b0,1'b0,1'b0,3'b000, 3'b001, 8'd2,1'b1,1'b1,1'b0,1'b0};
        tbl[21] = '{1'b1,1'b0,1'b0,3'b000, 3'b000, 8'd0,1'b0,1'b0,1'b0,1'b0};
        tbl[22] = '{1'b0,1'b1,1'b1,3'b110, 3'b110, 8'd1,1'b0,1'b0,1'b0,1'b0};
        tbl[23] = '{1'b0,1'b0,1'b0,3'b000, 3'b110, 8'd1,1'b1,1'b0,1'b0,1'b0};

        rst  = 1'b1;
        en   = 1'b0;
        fin  = 1'b0;
        resp = 3'b000;
        @(posedge clk);
        #1;

        for (int i = 0; i < 24; i++) begin
            x.sig   = tbl[i].sig;
            x.cnt   = tbl[i].cnt;
            x.cnt_s = tbl[i].cnt[1:0];
            x.done  = tbl[i].done;
            x.pa    = tbl[i].pa;
            x.pb    = tbl[i].pb;
            x.pc    = tbl[i].pc;
            x.ps    = 1'b0;
            cycle(tbl[i].rst, tbl[i].en, tbl[i].fin, tbl[i].resp, x, i);
        end

        // Long run with random gaps: 8-bit counter tracks, 2-bit counter saturates at 3.
        x = '{3'b000, 8'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        cycle(1'b1, 1'b0, 1'b0, 3'b000, x, 100);
        m_sig   = 3'b000;
        m_cnt   = 8'd0;
        m_cnt_s = 2'd0;
        for (int i = 0; i < 14; i++) begin
            e = (i == 0 || i == 13) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
            r = 3'($urandom_range(0, 7));
            if (e) begin
                m_sig   = model_step(m_sig, r);
                m_cnt   = m_cnt + 8'd1;
                m_cnt_s = (m_cnt_s == 2'd3) ? 2'd3 : m_cnt_s + 2'd1;
            end
            x = '{m_sig, m_cnt, m_cnt_s, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
            cycle(1'b0, e, (i == 13) ? 1'b1 : 1'($urandom_range(0, 1)) & ~e, r, x, 101 + i);
        end
        x.done = 1'b1;
        x.pa   = (m_sig == 3'b001) && (m_cnt == 8'd2);
        x.pb   = (m_sig == 3'b000) && (m_cnt == 8'd2);
        x.pc   = (m_sig == 3'b001) && (m_cnt == 8'd3);
        x.ps   = (m_sig == 3'b000) && (m_cnt_s == 2'd3);
        cycle(1'b0, 1'b1, 1'b1, 3'b111, x, 120);
        cycle(1'b0, 1'b1, 1'b0, 3'b101, x, 121);

        // Four responses then END on the fifth: saturating counter ends at 3 and must match EXP_COUNT=7 truncated.
        x = '{3'b000, 8'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        cycle(1'b1, 1'b0, 1'b0, 3'b000, x, 200);
        m_sig = 3'b000;
        for (int i = 0; i < 5; i++) begin
            r     = (i == 4) ? 3'b000 : 3'(i + 1);
            m_sig = model_step(m_sig, r);
            x.sig   = m_sig;
            x.cnt   = 8'(i + 1);
            x.cnt_s = (i >= 2) ? 2'd3 : 2'(i + 1);
            cycle(1'b0, 1'b1, (i == 4) ? 1'b1 : 1'b0, r, x, 201 + i);
        end
        x.done = 1'b1;
        x.pa   = 1'b0;
        x.pb   = 1'b0;
        x.pc   = 1'b0;
        x.ps   = (m_sig == 3'b000);
        cycle(1'b0, 1'b0, 1'b0, 3'b000, x, 206);

        if (done_b !== done_a || done_s !== done_a) begin
            tests++;
            fails++;
            $display("FAIL done_sync: got b=%0b s=%0b expected %0b", done_b, done_s, done_a);
        end else begin
            tests++;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
